// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS32 fetch path
package mips_pkg;
  localparam int ANCHO_INSTR = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  typedef enum logic {PEDIR, LISTO} estado_t;
endpackage

// File: rtl/siguiente_pc.sv
// siguiente_pc: next-PC priority mux (branch over jump over sequential)
module siguiente_pc #(
  parameter int ANCHO_DIR = 32
) (
  input  logic [ANCHO_DIR-1:0] pc_mas4,
  input  logic [31:0]          inmediato,
  input  logic [25:0]          dir_salto,
  input  logic                 fuentePc,
  input  logic                 salto,
  output logic [ANCHO_DIR-1:0] sig_pc
);
  logic [ANCHO_DIR-1:0] w_desp;
  logic [ANCHO_DIR-1:0] w_rama;
  logic [ANCHO_DIR-1:0] w_salto;
  // Word offset becomes a byte offset; the two bits shifted out are dropped
  assign w_desp  = ANCHO_DIR'(inmediato) << 2;
  assign w_rama  = pc_mas4 + w_desp;
  assign w_salto = {pc_mas4[ANCHO_DIR-1:28], dir_salto, 2'b00};
  // Branch has priority when both branch and jump are flagged
  always_comb
    sig_pc = fuentePc ? w_rama : salto ? w_salto : pc_mas4;
endmodule

// File: rtl/unidad_busqueda.sv
// unidad_busqueda: MIPS32 fetch unit with PC, req/ack memory port and instruction register
module unidad_busqueda
  import mips_pkg::*;
#(
  parameter int                   ANCHO_DIR = 32,
  parameter logic [ANCHO_DIR-1:0] PC_RESET  = PC_RESET_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fuentePc,
  input  logic [31:0]            inmediato,
  input  logic                   salto,
  input  logic [25:0]            dir_salto,
  input  logic                   avanzar,
  output logic                   mem_req,
  output logic [ANCHO_DIR-1:0]   mem_addr,
  input  logic                   mem_ack,
  input  logic [ANCHO_INSTR-1:0] mem_dato,
  output logic [ANCHO_INSTR-1:0] instr,
  output logic                   instr_valida,
  output logic [ANCHO_DIR-1:0]   pc,
  output logic [ANCHO_DIR-1:0]   pc_mas4
);
  estado_t                r_estado;
  logic                   r_req;
  logic [ANCHO_DIR-1:0]   r_pc;
  logic [ANCHO_INSTR-1:0] r_instr;
  logic [ANCHO_DIR-1:0]   w_sig_pc;
  logic                   w_captura;
  logic                   w_consume;
  assign w_captura    = r_estado == PEDIR && r_req && mem_ack;
  assign w_consume    = r_estado == LISTO && avanzar;
  assign pc_mas4      = r_pc + ANCHO_DIR'(PC_INC);
  assign pc           = r_pc;
  assign mem_addr     = r_pc;
  assign mem_req      = r_req;
  assign instr        = r_instr;
  assign instr_valida = r_estado == LISTO;
  siguiente_pc #(.ANCHO_DIR(ANCHO_DIR)) u_siguiente_pc (
    .pc_mas4  (pc_mas4),
    .inmediato(inmediato),
    .dir_salto(dir_salto),
    .fuentePc (fuentePc),
    .salto    (salto),
    .sig_pc   (w_sig_pc)
  );
  // FSM and request: req is registered so it rises the cycle after reset and right after a consume
  always_ff @(posedge clk)
    if (rst) begin
      r_estado <= PEDIR;
      r_req    <= 1'b0;
    end else if (r_estado == PEDIR) begin
      r_estado <= w_captura ? LISTO : PEDIR;
      r_req    <= !w_captura;
    end else begin
      r_estado <= avanzar ? PEDIR : LISTO;
      r_req    <= avanzar;
    end
  // PC moves only on consume; instruction captured only on an accepted ack
  always_ff @(posedge clk)
    if (rst) begin
      r_pc    <= PC_RESET;
      r_instr <= '0;
    end else begin
      if (w_captura) r_instr <= mem_dato;
      if (w_consume) r_pc <= w_sig_pc;
    end
endmodule

// File: tb/tb_unidad_busqueda.sv
// tb_unidad_busqueda: randomized self-checking bench for the fetch unit against a next-PC model
module tb_unidad_busqueda;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fuentePc = 1'b0;
  logic [31:0] inmediato = '0;
  logic        salto = 1'b0;
  logic [25:0] dir_salto = '0;
  logic        avanzar = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_dato = '0;
  logic [31:0] instr;
  logic        instr_valida;
  logic [31:0] pc;
  logic [31:0] pc_mas4;
  int          errores = 0;
  int          checks = 0;
  logic [31:0] m_pc = 32'h0;
  always #5 clk = ~clk;
  unidad_busqueda dut (
    .clk(clk), .rst(rst), .fuentePc(fuentePc), .inmediato(inmediato), .salto(salto),
    .dir_salto(dir_salto), .avanzar(avanzar), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_dato(mem_dato), .instr(instr), .instr_valida(instr_valida),
    .pc(pc), .pc_mas4(pc_mas4)
  );
  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: obtenido=%h esperado=%h", tag, obs, esp);
    end
  endtask
  function automatic logic [31:0] pc_ref(input logic [31:0] p, input logic f,
                                         input logic [31:0] imm, input logic s, input logic [25:0] d);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (f) return p4 + imm * 32'd4;
    if (s) return (p4 & 32'hF000_0000) | ({6'd0, d} * 32'd4);
    return p4;
  endfunction
  task automatic instr_ciclo(input int espera, input logic [31:0] dato, input int demora,
                             input logic f, input logic [31:0] imm, input logic s,
                             input logic [25:0] d, input logic espuria);
    int n;
    n = 0;
    while (!mem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    verificar("req", {31'd0, mem_req}, 32'd1);
    verificar("addr", mem_addr, m_pc);
    for (int i = 0; i < espera; i++) begin
      avanzar = 1'($urandom);
      @(negedge clk);
      verificar("addr_estable", mem_addr, m_pc);
      verificar("req_estable", {31'd0, mem_req}, 32'd1);
      verificar("valida_espera", {31'd0, instr_valida}, 32'd0);
    end
    mem_ack = 1'b1;
    mem_dato = dato;
    @(negedge clk);
    mem_ack = 1'b0;
    avanzar = 1'b0;
    mem_dato = $urandom;
    verificar("instr", instr, dato);
    verificar("valida", {31'd0, instr_valida}, 32'd1);
    verificar("req_baja", {31'd0, mem_req}, 32'd0);
    verificar("pc", pc, m_pc);
    verificar("pc_mas4", pc_mas4, m_pc + 32'd4);
    for (int i = 0; i < demora; i++) begin
      fuentePc = 1'($urandom);
      salto = 1'($urandom);
      inmediato = $urandom;
      if (espuria) begin
        mem_ack = 1'b1;
        mem_dato = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      verificar("instr_estable", instr, dato);
      verificar("pc_estable", pc, m_pc);
      verificar("valida_estable", {31'd0, instr_valida}, 32'd1);
    end
    avanzar = 1'b1;
    fuentePc = f;
    inmediato = imm;
    salto = s;
    dir_salto = d;
    @(negedge clk);
    avanzar = 1'b0;
    fuentePc = 1'($urandom);
    salto = 1'($urandom);
    inmediato = $urandom;
    dir_salto = 26'($urandom);
    m_pc = pc_ref(m_pc, f, imm, s, d);
    verificar("valida_cae", {31'd0, instr_valida}, 32'd0);
    verificar("pc_sig", pc, m_pc);
    verificar("req_sig", {31'd0, mem_req}, 32'd1);
    verificar("addr_sig", mem_addr, m_pc);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    verificar("rst_req", {31'd0, mem_req}, 32'd0);
    verificar("rst_instr", instr, 32'd0);
    verificar("rst_valida", {31'd0, instr_valida}, 32'd0);
    verificar("rst_pc", pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    instr_ciclo(0, 32'h2008_0005, 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      instr_ciclo(2, $urandom, 1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0);
    instr_ciclo(1, $urandom, 0, 1'b0, 32'd0, 1'b1, 26'h10, 1'b0);
    verificar("pc_0x40", m_pc, 32'h40);
    instr_ciclo(0, $urandom, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0);
    verificar("rama_atras", mem_addr, 32'h3C);
    instr_ciclo(0, $urandom, 0, 1'b0, 32'd0, 1'b1, 26'h10, 1'b0);
    instr_ciclo(0, $urandom, 0, 1'b0, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0);
    verificar("rama_no_tomada", mem_addr, 32'h44);
    instr_ciclo(0, $urandom, 0, 1'b1, 32'h03FF_FFF2, 1'b0, 26'd0, 1'b0);
    instr_ciclo(0, $urandom, 1, 1'b0, 32'd0, 1'b1, 26'h100, 1'b0);
    verificar("salto", mem_addr, 32'h1000_0400);
    instr_ciclo(0, $urandom, 0, 1'b0, 32'd0, 1'b1, 26'h4, 1'b0);
    instr_ciclo(0, $urandom, 0, 1'b1, 32'h1, 1'b1, 26'h3FF_FFFF, 1'b0);
    verificar("prioridad", mem_addr, 32'h1000_0018);
    instr_ciclo(0, $urandom, 0, 1'b1, 32'h3BFF_FFF8, 1'b0, 26'd0, 1'b0);
    verificar("pc_tope", mem_addr, 32'hFFFF_FFFC);
    instr_ciclo(1, 32'h1234_5678, 2, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1);
    verificar("vuelta", mem_addr, 32'h0);
    for (int i = 0; i < 40; i++)
      instr_ciclo(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
                  1'($urandom), $urandom, 1'($urandom), 26'($urandom), 1'($urandom));
    instr_ciclo(0, $urandom, 0, 1'b1, (32'h20 - m_pc - 32'd4) >> 2, 1'b0, 26'd0, 1'b0);
    verificar("pc_0x20", mem_addr, 32'h20);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_dato = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    verificar("rst_medio_valida", {31'd0, instr_valida}, 32'd0);
    verificar("rst_medio_instr", instr, 32'd0);
    verificar("rst_medio_req", {31'd0, mem_req}, 32'd0);
    verificar("rst_medio_pc", pc, 32'd0);
    @(negedge clk);
    m_pc = 32'h0;
    verificar("reinicio_req", {31'd0, mem_req}, 32'd1);
    verificar("reinicio_addr", mem_addr, 32'h0);
    mem_ack = 1'b1;
    mem_dato = 32'h0000_0001;
    @(negedge clk);
    mem_ack = 1'b0;
    verificar("rst_av_valida_pre", {31'd0, instr_valida}, 32'd1);
    rst = 1'b1;
    avanzar = 1'b1;
    fuentePc = 1'b1;
    inmediato = 32'd5;
    @(negedge clk);
    rst = 1'b0;
    avanzar = 1'b0;
    verificar("rst_av_pc", pc, 32'h0);
    verificar("rst_av_valida", {31'd0, instr_valida}, 32'd0);
    verificar("rst_av_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    instr_ciclo(0, 32'h8C01_0004, 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end
endmodule
